// File: rtl/cla_seq_add_ctrl_pkg.sv
// Shared definitions for the sequential 2-bit-slice carry-lookahead adder.
// State encodings, slice width and the step-counter sizing helper.
package cla_seq_add_ctrl_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // A single-step adder still needs a 1-bit counter so the compare is legal.
  function automatic int cnt_width(input int nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_add_ctrl_cla2_slice.sv
// Combinational 2-bit carry-lookahead slice in generate/propagate form.
// Exposes the internal carry c1 so the sequencer can derive signed overflow.
module cla2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       c1,
  output logic       cout
);

  logic [1:0] g;
  logic [1:0] p;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c1   = g[0] | (p[0] & cin);
  assign cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign sum  = p ^ {c1, cin};

endmodule

// File: rtl/cla_seq_add_ctrl.sv
// Sequencer that adds two WIDTH-bit operands two bits per clock through one
// shared cla2_slice, with a START/BUSY/DONE handshake.
//
// Handshake: start is sampled on every rising edge but only accepted in IDLE
// or DONE; busy is high for the WIDTH/2 RUN cycles, done pulses for one cycle
// when sum/cout/ovf become valid, and those results hold until the next result.
module cla_seq_add_ctrl
  import cla_seq_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           fsm_state
);

  localparam int NSTEP = WIDTH / SLICE_W;
  localparam int CW    = cnt_width(NSTEP);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [1:0]       s;
  logic             c1;
  logic             c2;
  logic             accept;
  logic             last_step;

  cla2_slice u_slice (
    .a    (op_a[1:0]),
    .b    (op_b[1:0]),
    .cin  (carry),
    .sum  (s),
    .c1   (c1),
    .cout (c2)
  );

  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_step = (state == ST_RUN) && (cnt == CW'(NSTEP - 1));
  // Concatenate-then-shift keeps WIDTH=2 legal: the result is just s.
  assign res_next  = WIDTH'({s, res} >> SLICE_W);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a  <= a;
        op_b  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        op_a  <= op_a >> SLICE_W;
        op_b  <= op_b >> SLICE_W;
        res   <= res_next;
        carry <= c2;
        cnt   <= cnt + 1'b1;
        if (last_step) begin
          sum  <= res_next;
          cout <= c2;
          ovf  <= c1 ^ c2;
        end
      end
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Randomized and directed bench for cla_seq_add_ctrl at WIDTH=8 and WIDTH=2,
// checked by per-instance scoreboards fed from an arithmetic reference model.
module tb_cla_seq_add_ctrl;
  import cla_seq_add_ctrl_pkg::*;

  localparam int W8 = 8;
  localparam int NSTEP8 = W8 / 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic          start = 1'b0;
  logic [W8-1:0] a = '0;
  logic [W8-1:0] b = '0;
  logic          cin = 1'b0;
  logic          busy, done, cout, ovf;
  logic [W8-1:0] sum;
  state_t        st8;

  cla_seq_add_ctrl #(.WIDTH(W8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .fsm_state(st8)
  );

  // WIDTH=2 instance
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;
  state_t     st2;

  cla_seq_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2),
    .fsm_state(st2)
  );

  // scoreboard state
  logic [W8+1:0] exp_q[$];   // {sum, cout, ovf}
  logic [3:0]    exp2_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [W8-1:0] held_sum = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition; overflow from the carry into the MSB.
  function automatic logic [W8+1:0] model8(input logic [W8-1:0] x, input logic [W8-1:0] y, input logic c);
    int unsigned full, low;
    full = int'(x) + int'(y) + int'(c);
    low  = int'(x[W8-2:0]) + int'(y[W8-2:0]) + int'(c);
    return {full[W8-1:0], full[W8], low[W8-1] ^ full[W8]};
  endfunction

  function automatic logic [3:0] model2(input logic [1:0] x, input logic [1:0] y, input logic c);
    int unsigned full, low;
    full = int'(x) + int'(y) + int'(c);
    low  = int'(x[0]) + int'(y[0]) + int'(c);
    return {full[1:0], full[2], low[1] ^ full[2]};
  endfunction

  // monitors
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done8: got done=1 expected no pending result at %0t", $time);
      end else begin
        logic [W8+1:0] e;
        e = exp_q.pop_front();
        check("sum8", 32'(sum), 32'(e[W8+1:2]));
        check("cout8", 32'(cout), 32'(e[1]));
        check("ovf8", 32'(ovf), 32'(e[0]));
      end
    end
    if (done2) begin
      if (exp2_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done2: got done=1 expected no pending result at %0t", $time);
      end else begin
        logic [3:0] e2;
        e2 = exp2_q.pop_front();
        check("sum2", 32'(sum2), 32'(e2[3:2]));
        check("cout2", 32'(cout2), 32'(e2[1]));
        check("ovf2", 32'(ovf2), 32'(e2[0]));
      end
    end
  end

  // driver tasks (entered and left on a negedge)
  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_add(input logic [W8-1:0] av, input logic [W8-1:0] bv, input logic cv, input bit hold);
    logic [W8+1:0] e;
    start = 1'b1; a = av; b = bv; cin = cv;
    e = model8(av, bv, cv);
    exp_q.push_back(e);
    @(negedge clk);
    for (int i = 0; i < NSTEP8; i++) begin
      if (hold) begin
        start = 1'b1; a = W8'($urandom); b = W8'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      check("sum_held_run", 32'(sum), 32'(held_sum));
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    held_sum = e[W8+1:2];
  endtask

  task automatic do_add2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    start2 = 1'b1; a2 = av; b2 = bv; cin2 = cv;
    exp2_q.push_back(model2(av, bv, cv));
    @(negedge clk);
    start2 = 1'b0;
    check("busy2_run", 32'(busy2), 32'd1);
    @(negedge clk);
    check("busy2_done", 32'(busy2), 32'd0);
    check("done2_pulse", 32'(done2), 32'd1);
  endtask

  task automatic reset_mid_run(input logic [W8-1:0] av, input logic [W8-1:0] bv);
    start = 1'b1; a = av; b = bv; cin = 1'b0;
    exp_q.push_back(model8(av, bv, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    void'(exp_q.pop_back());
    held_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(NSTEP8 + 3);
    check("rst_sum_after", 32'(sum), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed corner cases
    do_add(8'h5A, 8'h3C, 1'b0, 1'b0);
    idle(2);
    check("sum_held_idle", 32'(sum), 32'h96);
    do_add(8'hFF, 8'h01, 1'b0, 1'b0);
    idle(1);
    do_add(8'h00, 8'h00, 1'b1, 1'b0);
    idle(1);
    do_add(8'h80, 8'h80, 1'b0, 1'b1);
    idle(3);
    do_add(8'h7F, 8'h01, 1'b0, 1'b0);
    do_add(8'h01, 8'h02, 1'b0, 1'b0);
    idle(2);
    reset_mid_run(8'hC3, 8'h55);
    do_add(8'h10, 8'h20, 1'b0, 1'b0);
    idle(1);

    // randomized traffic with random gaps and START held during RUN
    for (int i = 0; i < 40; i++) begin
      do_add(W8'($urandom), W8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    // WIDTH=2: the spec corner case, then every input combination
    do_add2(2'b11, 2'b01, 1'b1);
    idle(1);
    for (int k = 0; k < 32; k++) begin
      do_add2(2'(k >> 3), 2'(k >> 1), 1'(k));
      idle($urandom_range(0, 1));
    end

    idle(3);
    check("queue8_empty", 32'(exp_q.size()), 32'd0);
    check("queue2_empty", 32'(exp2_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
